// File: rtl/sramqsys_cpu_oci_dct_ctrl.sv
// sramqsys_cpu_oci_dct_ctrl: packs 2-bit DCT trace atoms into 15-atom frames for the trace FIFO
// and sequences the end-of-test drain.
module sramqsys_cpu_oci_dct_ctrl #(
    parameter int ATOM_W = 2,
    parameter int ATOMS  = 15,
    parameter int CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    trace_enable,
    input  logic                    atom_valid,
    input  logic [ATOM_W-1:0]       atom,
    input  logic                    flush_req,
    input  logic                    test_ending,
    output logic                    frm_valid,
    input  logic                    frm_ready,
    output logic [ATOM_W*ATOMS-1:0] frm_data,
    output logic [CNT_W-1:0]        frm_count,
    output logic [ATOM_W*ATOMS-1:0] dct_buffer,
    output logic [CNT_W-1:0]        dct_count,
    output logic                    overflow,
    output logic                    test_has_ended
);
    localparam int BUF_W = ATOM_W * ATOMS;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(ATOMS);

    typedef enum logic [1:0] {RUN, DRAIN, ENDED} state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   dct_buffer_q, dct_buffer_d, frm_data_q, frm_data_d, next_buf;
    logic [CNT_W-1:0]   dct_count_q, dct_count_d, frm_count_q, frm_count_d, next_cnt;
    logic               frm_valid_q, frm_valid_d, overflow_q, overflow_d;
    logic               test_has_ended_q, test_has_ended_d;
    logic               flush_pending_q, flush_pending_d, ending_seen_q, ending_seen_d;
    logic               accept, drop, out_free, flush_eff, xfer;

    always_comb begin
        accept           = atom_valid & trace_enable & (dct_count_q != FULL) & (state_q == RUN);
        drop             = atom_valid & trace_enable & (dct_count_q == FULL) & (state_q == RUN);
        next_buf         = accept ? {dct_buffer_q[BUF_W-ATOM_W-1:0], atom} : dct_buffer_q;
        next_cnt         = accept ? dct_count_q + 1'b1 : dct_count_q;
        out_free         = !frm_valid_q | frm_ready;
        // DRAIN behaves as a permanently pending flush
        flush_eff        = flush_pending_q | flush_req | (state_q == DRAIN);
        xfer             = ((next_cnt == FULL) | (flush_eff & (next_cnt != '0))) & out_free;
        dct_buffer_d     = xfer ? '0 : next_buf;
        dct_count_d      = xfer ? '0 : next_cnt;
        frm_valid_d      = xfer | (frm_valid_q & !frm_ready);
        frm_data_d       = xfer ? next_buf : frm_data_q;
        frm_count_d      = xfer ? next_cnt : frm_count_q;
        flush_pending_d  = (xfer | (next_cnt == '0)) ? 1'b0 : flush_eff;
        overflow_d       = overflow_q | drop;
        ending_seen_d    = test_ending;
        state_d          = (state_q == RUN && test_ending && !ending_seen_q) ? DRAIN :
                           (state_q == DRAIN && dct_count_q == '0 && !frm_valid_q) ? ENDED : state_q;
        test_has_ended_d = test_has_ended_q | (state_q == ENDED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= RUN;
            dct_buffer_q     <= '0;
            dct_count_q      <= '0;
            frm_data_q       <= '0;
            frm_count_q      <= '0;
            frm_valid_q      <= 1'b0;
            overflow_q       <= 1'b0;
            test_has_ended_q <= 1'b0;
            flush_pending_q  <= 1'b0;
            ending_seen_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            dct_buffer_q     <= dct_buffer_d;
            dct_count_q      <= dct_count_d;
            frm_data_q       <= frm_data_d;
            frm_count_q      <= frm_count_d;
            frm_valid_q      <= frm_valid_d;
            overflow_q       <= overflow_d;
            test_has_ended_q <= test_has_ended_d;
            flush_pending_q  <= flush_pending_d;
            ending_seen_q    <= ending_seen_d;
        end
    end

    assign frm_valid      = frm_valid_q;
    assign frm_data       = frm_data_q;
    assign frm_count      = frm_count_q;
    assign dct_buffer     = dct_buffer_q;
    assign dct_count      = dct_count_q;
    assign overflow       = overflow_q;
    assign test_has_ended = test_has_ended_q;
endmodule

// File: tb/tb_sramqsys_cpu_oci_dct_ctrl.sv
// tb_sramqsys_cpu_oci_dct_ctrl: directed vectors and sequences for the DCT frame packer.
module tb_sramqsys_cpu_oci_dct_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        trace_enable = 1'b1, atom_valid = 1'b0, flush_req = 1'b0;
    logic        test_ending = 1'b0, frm_ready = 1'b1;
    logic [1:0]  atom = '0;
    logic        frm_valid, overflow, test_has_ended;
    logic [29:0] frm_data, dct_buffer;
    logic [3:0]  frm_count, dct_count;
    int          n_cmp = 0, n_fail = 0;

    sramqsys_cpu_oci_dct_ctrl dut (
        .clk(clk), .reset_n(reset_n), .trace_enable(trace_enable), .atom_valid(atom_valid),
        .atom(atom), .flush_req(flush_req), .test_ending(test_ending), .frm_valid(frm_valid),
        .frm_ready(frm_ready), .frm_data(frm_data), .frm_count(frm_count),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow),
        .test_has_ended(test_has_ended)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        te, av, fl;
        logic [1:0]  a;
        logic [29:0] buf_e;
        logic [3:0]  cnt_e;
        logic        fv_e;
        logic [3:0]  fc_e;
        logic [29:0] fd_e;
    } vec_t;
    vec_t vt[12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        test_ending = 1'b0;
        atom_valid  = 1'b0;
        flush_req   = 1'b0;
        trace_enable = 1'b1;
        reset_n     = 1'b0;
        @(negedge clk);
        reset_n     = 1'b1;
    endtask

    task automatic send(input logic [1:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            atom_valid = 1'b1;
            atom = a;
            tick();
        end
        atom_valid = 1'b0;
    endtask

    function automatic logic [127:0] all_out();
        return {57'd0, frm_valid, frm_count, frm_data, dct_count, dct_buffer, overflow, test_has_ended};
    endfunction

    initial begin
        logic        stable, ended_early;
        int          frames;
        logic [3:0]  fc_seen;
        logic [29:0] fd_seen;

        vt[0]  = '{te:1, av:1, fl:0, a:2'd3, buf_e:30'h3,  cnt_e:1, fv_e:0, fc_e:0, fd_e:30'h0};
        vt[1]  = '{te:1, av:1, fl:0, a:2'd2, buf_e:30'hE,  cnt_e:2, fv_e:0, fc_e:0, fd_e:30'h0};
        vt[2]  = '{te:1, av:1, fl:0, a:2'd1, buf_e:30'h39, cnt_e:3, fv_e:0, fc_e:0, fd_e:30'h0};
        vt[3]  = '{te:1, av:1, fl:1, a:2'd0, buf_e:30'h0,  cnt_e:0, fv_e:1, fc_e:4, fd_e:30'hE4};
        vt[4]  = '{te:1, av:0, fl:0, a:2'd0, buf_e:30'h0,  cnt_e:0, fv_e:0, fc_e:4, fd_e:30'hE4};
        vt[5]  = '{te:1, av:0, fl:1, a:2'd0, buf_e:30'h0,  cnt_e:0, fv_e:0, fc_e:4, fd_e:30'hE4};
        vt[6]  = '{te:1, av:0, fl:0, a:2'd0, buf_e:30'h0,  cnt_e:0, fv_e:0, fc_e:4, fd_e:30'hE4};
        vt[7]  = '{te:0, av:1, fl:0, a:2'd3, buf_e:30'h0,  cnt_e:0, fv_e:0, fc_e:4, fd_e:30'hE4};
        vt[8]  = '{te:1, av:1, fl:0, a:2'd2, buf_e:30'h2,  cnt_e:1, fv_e:0, fc_e:4, fd_e:30'hE4};
        vt[9]  = '{te:1, av:0, fl:0, a:2'd0, buf_e:30'h2,  cnt_e:1, fv_e:0, fc_e:4, fd_e:30'hE4};
        vt[10] = '{te:1, av:0, fl:1, a:2'd0, buf_e:30'h0,  cnt_e:0, fv_e:1, fc_e:1, fd_e:30'h2};
        vt[11] = '{te:1, av:0, fl:0, a:2'd0, buf_e:30'h0,  cnt_e:0, fv_e:0, fc_e:1, fd_e:30'h2};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_out(), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // full frame of 2'b01
        send(2'd1, 14);
        check("fill14_count", {frm_valid, dct_count}, {1'b0, 4'd14});
        send(2'd1, 1);
        check("full_frame", {frm_valid, frm_count, frm_data, dct_count}, {1'b1, 4'd15, 30'h15555555, 4'd0});
        tick();
        check("full_frame_clear", frm_valid, 1'b0);

        // table: flush with atom, empty flush, trace disabled
        do_reset();
        frm_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            trace_enable = vt[i].te;
            atom_valid   = vt[i].av;
            atom         = vt[i].a;
            flush_req    = vt[i].fl;
            tick();
            check($sformatf("vec%0d", i), {frm_valid, frm_count, frm_data, dct_count, dct_buffer},
                  {vt[i].fv_e, vt[i].fc_e, vt[i].fd_e, vt[i].cnt_e, vt[i].buf_e});
        end
        trace_enable = 1'b1;
        atom_valid = 1'b0;
        flush_req = 1'b0;

        // back-pressure and overflow
        do_reset();
        frm_ready = 1'b0;
        send(2'd2, 15);
        check("bp_first_frame", {frm_valid, frm_count, frm_data}, {1'b1, 4'd15, 30'h2AAAAAAA});
        stable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            send(2'd3, 1);
            if (frm_data !== 30'h2AAAAAAA || frm_count !== 4'd15 || frm_valid !== 1'b1) stable = 1'b0;
        end
        check("bp_overflow_clear", overflow, 1'b0);
        send(2'd1, 1);
        check("bp_held_stable", stable, 1'b1);
        check("bp_packer_full", {dct_count, dct_buffer, overflow}, {4'd15, 30'h3FFFFFFF, 1'b1});
        frm_ready = 1'b1;
        tick();
        check("bp_second_frame", {frm_valid, frm_count, frm_data, dct_count}, {1'b1, 4'd15, 30'h3FFFFFFF, 4'd0});
        tick();
        check("bp_after", {frm_valid, overflow}, {1'b0, 1'b1});

        // end-of-test drain, ready high
        do_reset();
        frm_ready = 1'b1;
        send(2'd1, 1); send(2'd2, 1); send(2'd3, 1); send(2'd0, 1); send(2'd1, 1);
        test_ending = 1'b1;
        tick();
        frames = 0; fc_seen = '0; fd_seen = '0;
        atom_valid = 1'b1;
        atom = 2'd3;
        for (int i = 0; i < 20 && !test_has_ended; i++) begin
            tick();
            if (frm_valid) begin
                frames++;
                fc_seen = frm_count;
                fd_seen = frm_data;
            end
        end
        atom_valid = 1'b0;
        check("drain_ended", test_has_ended, 1'b1);
        check("drain_frame", {frames[3:0], fc_seen, fd_seen}, {4'd1, 4'd5, 30'h1B1});
        check("drain_ignored", {dct_count, overflow}, {4'd0, 1'b0});
        test_ending = 1'b0;
        tick(); tick();
        check("ended_sticky", test_has_ended, 1'b1);

        // end-of-test drain, ready held low
        do_reset();
        frm_ready = 1'b0;
        send(2'd2, 5);
        test_ending = 1'b1;
        ended_early = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (test_has_ended) ended_early = 1'b1;
        end
        check("drain_bp_not_ended", ended_early, 1'b0);
        check("drain_bp_frame", {frm_valid, frm_count, frm_data}, {1'b1, 4'd5, 30'h2AA});
        frm_ready = 1'b1;
        for (int i = 0; i < 10 && !test_has_ended; i++) tick();
        check("drain_bp_ended", {test_has_ended, frm_valid}, {1'b1, 1'b0});

        // asynchronous reset mid-frame
        do_reset();
        frm_ready = 1'b0;
        send(2'd1, 15);
        send(2'd2, 7);
        check("pre_async", {frm_valid, dct_count}, {1'b1, 4'd7});
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset", all_out(), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        frm_ready = 1'b1;
        send(2'd3, 15);
        check("post_reset_frame", {frm_valid, frm_count, frm_data}, {1'b1, 4'd15, 30'h3FFFFFFF});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sramqsys_cpu_oci_dct_ctrl.md
Name: sramqsys_cpu_oci_dct_ctrl

Overview:
- Packs 2-bit direct-control-trace (DCT) atoms from the CPU OCI trace logic into a 30-bit frame buffer: 15 atoms per frame, with a 4-bit occupancy count.
- Hands completed or flushed frames to the trace output FIFO over a valid/ready handshake.
- Sequences end-of-test draining.
- Exposes live dct_buffer/dct_count and the test_ending/test_has_ended status consumed by the OCI test bench monitor.

Parameters:
- ATOM_W, 2, bits per trace atom.
- ATOMS, 15, atoms per frame; ATOM_W*ATOMS = 30 is the buffer width.
- CNT_W, 4, width of the occupancy counts.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- trace_enable  in  1  atoms accepted only when high.
- atom_valid  in  1  atom present this cycle.
- atom  in  2  trace atom value.
- flush_req  in  1  single-cycle pulse: emit partial frame.
- test_ending  in  1  level; rising edge starts the end-of-test drain.
- frm_valid  out  1  output frame register holds a frame.
- frm_ready  in  1  downstream accepts the frame when frm_valid & frm_ready.
- frm_data  out  30  frame atoms; oldest atom in the highest occupied slot.
- frm_count  out  4  number of atoms in frm_data (1..15).
- dct_buffer  out  30  live packer contents.
- dct_count  out  4  live packer occupancy (0..15).
- overflow  out  1  sticky: an atom was dropped.
- test_has_ended  out  1  sticky: drain complete.

Behaviour:
- Reset (async on reset_n low, any state, mid-frame included):
  - dct_buffer, dct_count, frm_data, frm_count, frm_valid, overflow, test_has_ended all clear to 0.
  - flush_pending and ending_seen clear; FSM enters RUN.
- Atom acceptance:
  - Accepted when atom_valid & trace_enable & dct_count<15 & state==RUN.
  - Accepted atom: next_buf = {dct_buffer[27:0], atom}, next_cnt = dct_count+1. Otherwise next_buf/next_cnt equal the current values.
- Drop:
  - atom_valid & trace_enable & dct_count==15 drops the atom and sets overflow (sticky until reset).
  - In DRAIN or ENDED, atoms are ignored silently; overflow is not set.
- Output register free when frm_valid==0, or frm_valid & frm_ready in the same cycle.
- Transfer:
  - Condition: (next_cnt==15 | (flush_pending_eff & next_cnt!=0)) & output free.
  - On transfer: frm_data<=next_buf, frm_count<=next_cnt, frm_valid<=1, dct_buffer<=0, dct_count<=0.
  - Latency: the 15th atom at cycle N gives frm_valid=1 at N+1 when the output is free.
- Handshake: when frm_valid & frm_ready and no transfer occurs, frm_valid<=0. frm_data and frm_count are held stable while frm_valid & !frm_ready.
- Back-pressure: packer full (15) with output busy holds the packer. Transfer happens the cycle after frm_ready asserts, back-to-back with no bubble.
- Flush handling:
  - flush_pending_eff = flush_pending | flush_req.
  - flush_pending sets on flush_req and clears on transfer, or when next_cnt==0.
  - An atom and flush_req in the same cycle: the atom is included in the flushed frame.
  - flush_req with an empty packer: no frame is emitted.
- FSM:
  - RUN -> DRAIN on test_ending rising edge (registered ending_seen); DRAIN forces flush_pending.
  - DRAIN -> ENDED when dct_count==0 & frm_valid==0. In ENDED, test_has_ended<=1.
  - ENDED is terminal until reset; test_ending deasserting has no effect.
- Count arithmetic is 4-bit unsigned and never exceeds 15; no wrap is possible.

Test Plan:
- Reset, then 15 accepted atoms 2'b01 with frm_ready=1 -> at cycle 16: frm_valid=1, frm_data=30'h15555555, frm_count=15, dct_count=0; frm_valid clears the next cycle.
- Atoms 3,2,1, then flush_req in the same cycle as atom 0 -> frm_data=30'h000000E4, frm_count=4, one frame only.
- frm_ready=0 and 31 atoms -> first frame held stable, packer at 15, 31st atom dropped with overflow=1. frm_ready=1 for two cycles -> second frame follows with no bubble, overflow stays 1.
- flush_req with dct_count=0 -> no frm_valid pulse, flush_pending clear next cycle.
- 5 atoms, test_ending rise, frm_ready=1 -> one frame with frm_count=5, further atoms ignored, test_has_ended=1 once drained. Same with frm_ready held 0 for 10 cycles -> test_has_ended stays 0 until the accept.
- reset_n pulsed low mid-frame (dct_count=7, frm_valid=1) -> all outputs 0 asynchronously, before the next clk edge; normal packing after release.
